layer_render_scheduler: RTL and testbench
=========================================

// Module: layer_render_scheduler
// PURPOSE
//  Sequences the address calculation unit across a frame. For each screen pixel (raster order),
//  walks the layer register file from layer 0 upward and skips unpopulated layers. For each
//  populated layer, presents its 128-bit register word and the pixel coordinate to the ACU and
//  waits for rdy, then issues one memory read request (RAM for sprites, flash for font layers).
//  Sits between the host-written layer register file and the ACU / memory read arbiter.
// PARAMETERS
//  NUM_LAYERS   16   layers in register file (power of 2, >=2)
//  SCREEN_W     320  pixels per line
//  SCREEN_H     240  lines per frame
//  COORD_W      9    width of pixel coordinate outputs
// PORTS
//  clk               in   1                single clock, all logic rising-edge
//  reset             in   1                asynchronous, active-high
//  frameStart        in   1                one-cycle pulse; starts a frame when idle
//  layerRegFile      in   NUM_LAYERS*128   layer n at [n*128 +: 128]; bit0 isPopulated, bit1 isSprite
//  busy              out  1                high from frame accept until frameDone
//  pixelDone         out  1                one-cycle pulse after last layer of a pixel
//  frameDone         out  1                one-cycle pulse after last pixel of frame
//  acuLayerRegisters out  128              register word of layer under calculation
//  acuXPixel         out  COORD_W          current x
//  acuYPixel         out  COORD_W          current y
//  acuStart          out  1                one-cycle pulse launching an ACU calculation
//  acuRdy            in   1                ACU result valid (level)
//  acuRamOffset      in   27               ACU ramAddressOffsetBytes
//  acuFlashOffset    in   30               ACU flashAddressOffsetBits
//  memReqValid       out  1                read request valid
//  memReqReady       in   1                arbiter accepts when valid&&ready
//  memReqIsFlash     out  1                1 = flash (bit offset), 0 = RAM (byte offset)
//  memReqAddr        out  30               RAM offset zero-extended, or flash offset
//  memReqLayer       out  $clog2(NUM_LAYERS) originating layer index
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; x=y=layer=0. Reset mid-frame aborts with no done pulses.
//  FSM: IDLE -> SCAN -> CALC -> WAIT -> ISSUE -> SCAN ... ; SCAN -> PIXEL_END when layers exhausted.
//  IDLE: frameStart=1 -> x=y=0, layer=0, busy=1, go SCAN. frameStart while busy is ignored.
//  SCAN: one layer examined per cycle. isPopulated=1 -> latch register word to acuLayerRegisters,
//        go CALC. Otherwise layer++. Past NUM_LAYERS-1 -> PIXEL_END.
//  CALC: acuStart=1 for exactly one cycle -> WAIT. acuRdy in the CALC cycle is ignored (stale).
//  WAIT: hold inputs stable; on acuRdy=1 latch memReqIsFlash=~isSprite and memReqAddr from the
//        matching offset, memReqValid=1 -> ISSUE.
//  ISSUE: valid, addr, isFlash and layer held stable until valid&&ready. Then valid=0, layer++,
//        -> SCAN, or -> PIXEL_END if layer was NUM_LAYERS-1.
//  PIXEL_END: pixelDone pulse. x wraps SCREEN_W-1 -> 0 with y++. At (SCREEN_W-1, SCREEN_H-1):
//        frameDone pulses in the same cycle, busy=0 next cycle, -> IDLE. Else layer=0 -> SCAN.
//  No populated layers: pixel costs NUM_LAYERS SCAN cycles + 1 PIXEL_END cycle.
//  Populated layer cost: 1 SCAN + 1 CALC + ACU latency + >=1 ISSUE.
//  acuXPixel/acuYPixel always reflect current x/y, zero-extended to COORD_W.
//  layerRegFile is sampled live; the host must not modify it while busy=1 (not checked).
// STRUCTURE
//  Package gpu_sched_pkg: state enum sched_state_t; LAYER_REG_W=128; bit indices
//   LREG_POPULATED=0, LREG_SPRITE=1; RAM_OFS_W=27; FLASH_OFS_W=30.
//  Sub-module raster_counter: x/y counters with wrap and last-pixel flag; FSM stays in this module.
// TESTING (bench: SCREEN_W=4, SCREEN_H=2, NUM_LAYERS=4, ACU model rdy 3 cycles after acuStart)
//  1 Only layer 2 populated, sprite; ACU ram=0x123 -> per pixel one req {isFlash=0, addr=0x123,
//    layer=2}; 8 pixelDone, 1 frameDone, then busy=0.
//  2 Layers 0,3 populated (0 font, 3 sprite) -> two reqs per pixel in order layer 0 (isFlash=1)
//    then 3; acuX/Y sequence (0,0),(1,0)..(3,1).
//  3 No layers populated -> pixelDone every 5 cycles; frameDone 40 cycles after frameStart.
//  4 memReqReady held low 10 cycles -> valid/addr/layer stable throughout; exactly one handshake.
//  5 frameStart pulsed mid-frame -> ignored, no restart; reset asserted mid-WAIT -> all outputs 0
//    immediately, no frameDone; new frameStart after release runs a full frame.
//  6 acuRdy high during the CALC cycle (stale) -> no request until rdy asserts in WAIT.

Source files
------------

// File: rtl/gpu_sched_pkg.sv
// Shared types and constants for the layer render scheduler.
package gpu_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_CALC,
        S_WAIT,
        S_ISSUE,
        S_PIXEL_END
    } sched_state_t;

    localparam int LAYER_REG_W    = 128;
    localparam int LREG_POPULATED = 0;
    localparam int LREG_SPRITE    = 1;
    localparam int RAM_OFS_W      = 27;
    localparam int FLASH_OFS_W    = 30;
    localparam int MEM_ADDR_W     = 30;

endpackage

// File: rtl/layer_render_scheduler_if.sv
// ACU launch/result signals and memory read request channel of the scheduler.
interface layer_render_scheduler_if
    import gpu_sched_pkg::*;
#(
    parameter int NUM_LAYERS = 16,
    parameter int COORD_W    = 9
);
    localparam int LIDX_W = $clog2(NUM_LAYERS);

    logic [LAYER_REG_W-1:0] acuLayerRegisters;
    logic [COORD_W-1:0]     acuXPixel;
    logic [COORD_W-1:0]     acuYPixel;
    logic                   acuStart;
    logic                   acuRdy;
    logic [RAM_OFS_W-1:0]   acuRamOffset;
    logic [FLASH_OFS_W-1:0] acuFlashOffset;
    logic                   memReqValid;
    logic                   memReqReady;
    logic                   memReqIsFlash;
    logic [MEM_ADDR_W-1:0]  memReqAddr;
    logic [LIDX_W-1:0]      memReqLayer;

    modport master (
        output acuLayerRegisters, acuXPixel, acuYPixel, acuStart,
        input  acuRdy, acuRamOffset, acuFlashOffset,
        output memReqValid, memReqIsFlash, memReqAddr, memReqLayer,
        input  memReqReady
    );

    modport slave (
        input  acuLayerRegisters, acuXPixel, acuYPixel, acuStart,
        output acuRdy, acuRamOffset, acuFlashOffset,
        input  memReqValid, memReqIsFlash, memReqAddr, memReqLayer,
        output memReqReady
    );

endinterface

// File: rtl/layer_render_scheduler_raster_counter.sv
// Raster-order pixel position: x wraps into a y step, flags the last pixel of the frame.
module raster_counter #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int COORD_W  = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               advance_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               x_at_end;
    logic               y_at_end;

    assign x_at_end = (x_q == X_MAX);
    assign y_at_end = (y_q == Y_MAX);

    // Next position: clear on frame accept, step once per finished pixel
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_at_end) begin
                x_d = '0;
                y_d = y_at_end ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_at_end && y_at_end;

endmodule

// File: rtl/layer_render_scheduler.sv
// Walks the layer register file per pixel, launches ACU calculations and issues memory reads.
module layer_render_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int NUM_LAYERS = 16,
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int COORD_W    = 9
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frameStart,
    input  logic [NUM_LAYERS*LAYER_REG_W-1:0] layerRegFile,
    output logic                              busy,
    output logic                              pixelDone,
    output logic                              frameDone,
    layer_render_scheduler_if.master          bus
);
    localparam int LIDX_W = $clog2(NUM_LAYERS);

    sched_state_t           state_q, state_d;
    logic [LIDX_W-1:0]      layer_q, layer_d;
    logic [LAYER_REG_W-1:0] word_q, word_d;
    logic                   is_flash_q, is_flash_d;
    logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
    logic                   busy_q, busy_d;

    logic [LAYER_REG_W-1:0] cur_word;
    logic                   layer_last;
    logic                   last_pixel;
    logic                   raster_clear;
    logic                   raster_advance;
    logic                   acu_start;
    logic                   req_valid;
    logic [COORD_W-1:0]     x_pix;
    logic [COORD_W-1:0]     y_pix;

    assign cur_word   = layerRegFile[int'(layer_q)*LAYER_REG_W +: LAYER_REG_W];
    assign layer_last = (layer_q == LIDX_W'(NUM_LAYERS - 1));

    raster_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .COORD_W  (COORD_W)
    ) u_raster (
        .clk       (clk),
        .rst       (reset),
        .clear_i   (raster_clear),
        .advance_i (raster_advance),
        .x_o       (x_pix),
        .y_o       (y_pix),
        .last_o    (last_pixel)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (frameStart) state_d = S_SCAN;
            S_SCAN: begin
                if (cur_word[LREG_POPULATED]) state_d = S_CALC;
                else if (layer_last)          state_d = S_PIXEL_END;
            end
            S_CALC:      state_d = S_WAIT;
            S_WAIT:      if (bus.acuRdy) state_d = S_ISSUE;
            S_ISSUE:     if (bus.memReqReady) state_d = layer_last ? S_PIXEL_END : S_SCAN;
            S_PIXEL_END: state_d = last_pixel ? S_IDLE : S_SCAN;
            default:     state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs and raster control
    always_comb begin
        pixelDone      = 1'b0;
        frameDone      = 1'b0;
        acu_start      = 1'b0;
        req_valid      = 1'b0;
        raster_clear   = 1'b0;
        raster_advance = 1'b0;
        case (state_q)
            S_IDLE:      raster_clear = frameStart;
            S_CALC:      acu_start = 1'b1;
            S_ISSUE:     req_valid = 1'b1;
            S_PIXEL_END: begin
                pixelDone      = 1'b1;
                frameDone      = last_pixel;
                raster_advance = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values: layer walk, latched register word, request fields, busy
    always_comb begin
        layer_d    = layer_q;
        word_d     = word_q;
        is_flash_d = is_flash_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: if (frameStart) begin
                layer_d = '0;
                busy_d  = 1'b1;
            end
            S_SCAN: begin
                if (cur_word[LREG_POPULATED]) word_d  = cur_word;
                else                          layer_d = layer_q + LIDX_W'(1);
            end
            S_WAIT: if (bus.acuRdy) begin
                is_flash_d = ~word_q[LREG_SPRITE];
                addr_d     = word_q[LREG_SPRITE]
                           ? {{(MEM_ADDR_W-RAM_OFS_W){1'b0}}, bus.acuRamOffset}
                           : bus.acuFlashOffset;
            end
            S_ISSUE:     if (bus.memReqReady) layer_d = layer_q + LIDX_W'(1);
            S_PIXEL_END: begin
                layer_d = '0;
                if (last_pixel) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_q    <= '0;
            word_q     <= '0;
            is_flash_q <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            layer_q    <= layer_d;
            word_q     <= word_d;
            is_flash_q <= is_flash_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
        end
    end

    assign busy                  = busy_q;
    assign bus.acuLayerRegisters = word_q;
    assign bus.acuXPixel         = x_pix;
    assign bus.acuYPixel         = y_pix;
    assign bus.acuStart          = acu_start;
    assign bus.memReqValid       = req_valid;
    assign bus.memReqIsFlash     = is_flash_q;
    assign bus.memReqAddr        = addr_q;
    assign bus.memReqLayer       = layer_q;

endmodule

// File: tb/tb_layer_render_scheduler.sv
// Directed bench: 4x2 screen, 4 layers, ACU answers 3 cycles after acuStart.
module tb_layer_render_scheduler;
    localparam int NL = 4;
    localparam int SW = 4;
    localparam int SH = 2;
    localparam int CW = 9;

    typedef struct {
        logic [3:0]  pop;
        logic [3:0]  spr;
        logic [26:0] ram;
        logic [29:0] flash;
        int          exp_reqs;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic         isf;
        logic [29:0]  addr;
        logic [1:0]   layer;
        logic [8:0]   x;
        logic [8:0]   y;
        logic [127:0] word;
    } req_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frameStart = 1'b0;
    logic [NL*128-1:0] regfile = '0;
    logic            busy, pixelDone, frameDone;
    logic            stale_mode = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int req_base = 0;
    int pix_base = 0;
    int fd_base  = 0;
    vec_t vecs[5];

    layer_render_scheduler_if #(.NUM_LAYERS(NL), .COORD_W(CW)) bus_if ();

    layer_render_scheduler #(
        .NUM_LAYERS (NL),
        .SCREEN_W   (SW),
        .SCREEN_H   (SH),
        .COORD_W    (CW)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .frameStart   (frameStart),
        .layerRegFile (regfile),
        .busy         (busy),
        .pixelDone    (pixelDone),
        .frameDone    (frameDone),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    // ACU model: rdy pulses in the third cycle after the acuStart cycle; optional stale rdy in CALC
    int acu_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            acu_cnt = 0;
            bus_if.acuRdy = 1'b0;
        end else if (bus_if.acuStart) begin
            acu_cnt = 3;
            bus_if.acuRdy = stale_mode;
        end else if (acu_cnt > 0) begin
            acu_cnt--;
            bus_if.acuRdy = (acu_cnt == 0);
        end else begin
            bus_if.acuRdy = 1'b0;
        end
    end

    // Monitor: records handshakes, pixel positions at pixelDone and frame timing
    req_t        req_q[$];
    logic [17:0] pix_q[$];
    int   cyc = 0;
    int   fd_cnt = 0;
    int   fd_cyc = 0;
    int   start_cyc = 0;
    logic fd_busy = 1'b0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (frameStart && !busy) start_cyc = cyc;
            if (bus_if.memReqValid && bus_if.memReqReady)
                req_q.push_back('{bus_if.memReqIsFlash, bus_if.memReqAddr, bus_if.memReqLayer,
                                  bus_if.acuXPixel, bus_if.acuYPixel, bus_if.acuLayerRegisters});
            if (pixelDone) pix_q.push_back({bus_if.acuXPixel, bus_if.acuYPixel});
            if (frameDone) begin
                fd_cnt++;
                fd_cyc  = cyc;
                fd_busy = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mkword(input int l, input logic pop, input logic spr);
        return {32'hDEAD_0000 + 32'(l), 64'h0123_4567_89AB_CDEF, 16'hA5A5, 8'(l), 6'b0, spr, pop};
    endfunction

    function automatic int nth_layer(input logic [3:0] pop, input int n);
        int c = 0;
        for (int l = 0; l < NL; l++) begin
            if (pop[l]) begin
                if (c == n) return l;
                c++;
            end
        end
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  128'(busy), '0);
        check({tag, "_pixd"},  128'(pixelDone), '0);
        check({tag, "_frmd"},  128'(frameDone), '0);
        check({tag, "_start"}, 128'(bus_if.acuStart), '0);
        check({tag, "_valid"}, 128'(bus_if.memReqValid), '0);
        check({tag, "_isf"},   128'(bus_if.memReqIsFlash), '0);
        check({tag, "_addr"},  128'(bus_if.memReqAddr), '0);
        check({tag, "_layer"}, 128'(bus_if.memReqLayer), '0);
        check({tag, "_x"},     128'(bus_if.acuXPixel), '0);
        check({tag, "_y"},     128'(bus_if.acuYPixel), '0);
        check({tag, "_word"},  bus_if.acuLayerRegisters, '0);
    endtask

    task automatic prepare(input int vi);
        for (int l = 0; l < NL; l++)
            regfile[l*128 +: 128] = mkword(l, vecs[vi].pop[l], vecs[vi].spr[l]);
        bus_if.acuRamOffset   = vecs[vi].ram;
        bus_if.acuFlashOffset = vecs[vi].flash;
        req_base = req_q.size();
        pix_base = pix_q.size();
        fd_base  = fd_cnt;
    endtask

    task automatic start_frame();
        frameStart = 1'b1;
        step(1);
        frameStart = 1'b0;
    endtask

    task automatic finish_frame(input int vi, input int extra, input string tag);
        int   n = 0;
        int   p;
        int   nreq;
        int   npix;
        int   l;
        int   pix;
        req_t r;
        while (fd_cnt == fd_base && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_frame_seen"}, 128'(fd_cnt != fd_base), 128'(1));
        check({tag, "_cycles"}, 128'(fd_cyc - start_cyc), 128'(vecs[vi].exp_cycles + extra));
        check({tag, "_fd_cnt"}, 128'(fd_cnt - fd_base), 128'(1));
        check({tag, "_busy_at_fd"}, 128'(fd_busy), 128'(1));
        check({tag, "_busy_after"}, 128'(busy), '0);
        npix = pix_q.size() - pix_base;
        check({tag, "_pix_cnt"}, 128'(npix), 128'(SW * SH));
        for (int j = 0; j < npix && j < SW * SH; j++)
            check($sformatf("%s_pix%0d_xy", tag, j), 128'(pix_q[pix_base + j]),
                  128'({9'(j % SW), 9'(j / SW)}));
        nreq = req_q.size() - req_base;
        check({tag, "_req_cnt"}, 128'(nreq), 128'(vecs[vi].exp_reqs));
        p = vecs[vi].exp_reqs / (SW * SH);
        for (int k = 0; k < nreq && k < vecs[vi].exp_reqs; k++) begin
            r   = req_q[req_base + k];
            pix = k / p;
            l   = nth_layer(vecs[vi].pop, k % p);
            check($sformatf("%s_req%0d_isf", tag, k), 128'(r.isf), 128'(!vecs[vi].spr[l]));
            check($sformatf("%s_req%0d_addr", tag, k), 128'(r.addr),
                  vecs[vi].spr[l] ? 128'(vecs[vi].ram) : 128'(vecs[vi].flash));
            check($sformatf("%s_req%0d_layer", tag, k), 128'(r.layer), 128'(l));
            check($sformatf("%s_req%0d_xy", tag, k), 128'({r.x, r.y}),
                  128'({9'(pix % SW), 9'(pix / SW)}));
            check($sformatf("%s_req%0d_word", tag, k), r.word, mkword(l, 1'b1, vecs[vi].spr[l]));
        end
    endtask

    initial begin
        int n;
        int starts;
        // pop, spr, ram, flash, requests per frame, frameStart->frameDone cycles
        vecs[0] = '{4'b0100, 4'b0100, 27'h000_0123, 30'h03AB_CDEF, 8,  80};
        vecs[1] = '{4'b1001, 4'b1110, 27'h7FF_FFFF, 30'h2AAA_AAAA, 16, 120};
        vecs[2] = '{4'b0000, 4'b1111, 27'h000_0055, 30'h0000_0066, 0,  40};
        vecs[3] = '{4'b1111, 4'b0101, 27'h000_0001, 30'h3FFF_FFFF, 32, 200};
        vecs[4] = '{4'b0010, 4'b0000, 27'h000_0777, 30'h0000_0000, 8,  80};

        bus_if.memReqReady    = 1'b1;
        bus_if.acuRamOffset   = '0;
        bus_if.acuFlashOffset = '0;

        rst = 1'b1;
        step(3);
        check_zero("reset");
        rst = 1'b0;
        step(2);
        check("idle_busy", 128'(busy), '0);

        for (int i = 0; i < 5; i++) begin
            prepare(i);
            start_frame();
            finish_frame(i, 0, $sformatf("vec%0d", i));
            step(2);
        end

        // Back-pressure: ready low for 10 cycles of ISSUE
        bus_if.memReqReady = 1'b0;
        prepare(0);
        start_frame();
        n = 0;
        while (!bus_if.memReqValid && n < 200) begin
            step(1);
            n++;
        end
        check("stall_valid_seen", 128'(bus_if.memReqValid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall%0d_valid", i), 128'(bus_if.memReqValid), 128'(1));
            check($sformatf("stall%0d_addr", i), 128'(bus_if.memReqAddr), 128'(30'h123));
            check($sformatf("stall%0d_layer", i), 128'(bus_if.memReqLayer), 128'(2));
            check($sformatf("stall%0d_isf", i), 128'(bus_if.memReqIsFlash), '0);
            check($sformatf("stall%0d_hs", i), 128'(req_q.size() - req_base), '0);
            step(1);
        end
        bus_if.memReqReady = 1'b1;
        step(1);
        check("stall_one_hs", 128'(req_q.size() - req_base), 128'(1));
        finish_frame(0, 10, "stall");
        step(2);

        // frameStart while busy must not restart the frame
        prepare(2);
        start_frame();
        step(12);
        start_frame();
        check("midstart_busy", 128'(busy), 128'(1));
        finish_frame(2, 0, "midstart");
        step(2);

        // Reset during WAIT of pixel 2 aborts the frame
        prepare(0);
        start_frame();
        n = 0;
        starts = 0;
        while (starts < 3 && n < 500) begin
            if (bus_if.acuStart) starts++;
            if (starts < 3) step(1);
            n++;
        end
        check("abort_starts", 128'(starts), 128'(3));
        step(1);
        check("abort_pre_x", 128'(bus_if.acuXPixel), 128'(2));
        check("abort_pre_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check_zero("abort");
        step(3);
        check("abort_no_fd", 128'(fd_cnt - fd_base), '0);
        check("abort_busy", 128'(busy), '0);
        rst = 1'b0;
        step(2);
        prepare(0);
        start_frame();
        finish_frame(0, 0, "post_rst");
        step(2);

        // Stale rdy during CALC must be ignored
        stale_mode = 1'b1;
        prepare(0);
        start_frame();
        finish_frame(0, 0, "stale");
        stale_mode = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
